hex_entry_reg: RTL and testbench

Parametrised hex-digit entry register for keypad and switch front-ends. It shifts DIGITS nibble-wide digits left on `add` and right on `del`, and supports a parallel load and a clear. A lockout timer debounces the `add`/`del`/`clr` commands, and the block tracks how many digits have been entered. It sits between the input synchroniser/keypad decoder and the display or ALU operand path. It supersedes the fixed 16-bit, 4-digit entry register.

---
 rtl/hex_entry_reg.sv | 146 ++++++++++++++
 tb/tb_hex_entry_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_reg.sv
// Hex-digit entry register: edge-triggered add/del/clr with a post-command lockout,
// parallel load and a digit counter. Define HEX_ENTRY_SAT_EN for saturating mode with sticky ovf.
module hex_entry_reg #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int LOCKOUT = 10_000_000
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [DIGITS*DIGIT_W-1:0]     data_i,
  input  logic                          load,
  input  logic [DIGIT_W-1:0]            hex,
  input  logic                          add,
  input  logic                          del,
  input  logic                          clr,
  output logic [DIGITS*DIGIT_W-1:0]     data_o,
  output logic [$clog2(DIGITS+1)-1:0]   count,
  output logic                          full,
`ifdef HEX_ENTRY_SAT_EN
  output logic                          ovf,
`endif
  output logic                          busy
);

  localparam int DW   = DIGITS * DIGIT_W;
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam int LCW  = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DIGITS);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCKOUT - 1);

  logic          add_q, add_qq, del_q, del_qq, clr_q, clr_qq;
  logic [DW-1:0] data_q, data_d;
  logic [CNTW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic [LCW-1:0] lock_q, lock_d;
  logic          add_fire_s, del_fire_s, clr_fire_s, is_full_s;
`ifdef HEX_ENTRY_SAT_EN
  logic          ovf_q, ovf_d;
`endif

  // Commands fire on a rising edge of the registered input, only outside lockout.
  assign add_fire_s = add_q & ~add_qq & ~busy_q;
  assign del_fire_s = del_q & ~del_qq & ~busy_q;
  assign clr_fire_s = clr_q & ~clr_qq & ~busy_q;
  assign is_full_s  = (count_q == FULL_CNT);

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    busy_d  = busy_q;
    lock_d  = lock_q;
`ifdef HEX_ENTRY_SAT_EN
    ovf_d   = ovf_q;
`endif

    if (busy_q) begin
      if (lock_q == LOCK_MAX) begin
        busy_d = 1'b0;
        lock_d = '0;
      end else begin
        lock_d = lock_q + LCW'(1);
      end
    end else begin
      lock_d = '0;
    end

    // Load outranks every command and leaves the lockout running untouched.
    if (load) begin
      data_d  = data_i;
      count_d = FULL_CNT;
    end else if (clr_fire_s) begin
      data_d  = '0;
      count_d = '0;
`ifdef HEX_ENTRY_SAT_EN
      ovf_d   = 1'b0;
`endif
      busy_d  = 1'b1;
      lock_d  = '0;
    end else if (add_fire_s) begin
      busy_d = 1'b1;
      lock_d = '0;
      if (is_full_s) begin
`ifdef HEX_ENTRY_SAT_EN
        ovf_d  = 1'b1;
`else
        data_d = {data_q[(DIGITS-1)*DIGIT_W-1:0], hex};
`endif
      end else begin
        data_d  = {data_q[(DIGITS-1)*DIGIT_W-1:0], hex};
        count_d = count_q + CNTW'(1);
      end
    end else if (del_fire_s) begin
      data_d = {{DIGIT_W{1'b0}}, data_q[DW-1:DIGIT_W]};
      busy_d = 1'b1;
      lock_d = '0;
      if (count_q != '0) begin
        count_d = count_q - CNTW'(1);
      end else begin
        count_d = '0;
      end
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      add_q   <= 1'b0;
      add_qq  <= 1'b0;
      del_q   <= 1'b0;
      del_qq  <= 1'b0;
      clr_q   <= 1'b0;
      clr_qq  <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      lock_q  <= '0;
`ifdef HEX_ENTRY_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      add_q   <= add;
      add_qq  <= add_q;
      del_q   <= del;
      del_qq  <= del_q;
      clr_q   <= clr;
      clr_qq  <= clr_q;
      data_q  <= data_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
`ifdef HEX_ENTRY_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign data_o = data_q;
  assign count  = count_q;
  assign full   = is_full_s;
  assign busy   = busy_q;
`ifdef HEX_ENTRY_SAT_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_hex_entry_reg.sv
// Scoreboard bench for hex_entry_reg (DIGITS=4, DIGIT_W=4, LOCKOUT=4); follows HEX_ENTRY_SAT_EN.
module tb_hex_entry_reg;

  localparam int LOCKOUT = 4;
  localparam int K_ADD = 1;
  localparam int K_DEL = 2;
  localparam int K_CLR = 4;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  hex = 4'h0;
  logic        add = 1'b0;
  logic        del = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] data_o;
  logic [2:0]  count;
  logic        full;
  logic        busy;
`ifdef HEX_ENTRY_SAT_EN
  logic        ovf;
`endif

  hex_entry_reg #(.DIGITS(4), .DIGIT_W(4), .LOCKOUT(LOCKOUT)) dut (
    .sys_clk(sys_clk), .rst(rst), .data_i(data_i), .load(load), .hex(hex),
    .add(add), .del(del), .clr(clr), .data_o(data_o), .count(count), .full(full),
`ifdef HEX_ENTRY_SAT_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  count;
    logic        busy;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] md = 16'h0000;
  logic [2:0]  mc = 3'd0;
  logic        mo = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted command (priority clr > add > del).
  task automatic model_cmd(input int m, input logic [3:0] h);
    if ((m & K_CLR) != 0) begin
      md = 16'h0000; mc = 3'd0; mo = 1'b0;
    end else if ((m & K_ADD) != 0) begin
      if (mc == 3'd4) begin
`ifdef HEX_ENTRY_SAT_EN
        mo = 1'b1;
`else
        md = {md[11:0], h};
`endif
      end else begin
        md = {md[11:0], h};
        mc = mc + 3'd1;
      end
    end else if ((m & K_DEL) != 0) begin
      md = md >> 4;
      if (mc != 3'd0) mc = mc - 3'd1;
    end
  endtask

  task automatic push_exp(input logic b);
    exp_t e;
    e.data = md; e.count = mc; e.busy = b; e.ovf = mo;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_data"}, 32'(data_o), 32'(e.data));
      check_val({tag, "_count"}, 32'(count), 32'(e.count));
      check_val({tag, "_full"}, 32'(full), 32'(e.count == 3'd4));
      check_val({tag, "_busy"}, 32'(busy), 32'(e.busy));
`ifdef HEX_ENTRY_SAT_EN
      check_val({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    end
  endtask

  task automatic set_cmd(input int m, input logic v);
    if ((m & K_ADD) != 0) add = v;
    if ((m & K_DEL) != 0) del = v;
    if ((m & K_CLR) != 0) clr = v;
  endtask

  // One-cycle command pulse; returns at the negedge after the command takes effect.
  task automatic pulse(input int m, input logic [3:0] h);
    @(negedge sys_clk);
    hex = h;
    set_cmd(m, 1'b1);
    @(negedge sys_clk);
    set_cmd(m, 1'b0);
    @(negedge sys_clk);
  endtask

  // Full command: check the immediate result, measure lockout length, check idle state.
  task automatic run_cmd(input string tag, input int m, input logic [3:0] h, input bit swallow);
    int n;
    model_cmd(m, h);
    push_exp(1'b1);
    push_exp(1'b0);
    pulse(m, h);
    check_out(tag);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b1) break;
      n++;
      if (swallow && k == 0) begin add = 1'b1; hex = 4'hF; end
      if (swallow && k == 1) add = 1'b0;
      @(negedge sys_clk);
    end
    check_val({tag, "_busy_len"}, 32'(n), 32'(LOCKOUT));
    check_out({tag, "_idle"});
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge sys_clk);
    load = 1'b1; data_i = v;
    @(negedge sys_clk);
    load = 1'b0;
    md = v; mc = 3'd4;
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    push_exp(1'b0);
    check_out("reset");

    run_cmd("add_a", K_ADD, 4'hA, 1'b0);
    run_cmd("add_b", K_ADD, 4'hB, 1'b0);
    run_cmd("add_c_swallow", K_ADD, 4'hC, 1'b1);

    for (int i = 0; i < 4; i++) run_cmd($sformatf("del%0d", i), K_DEL, 4'h0, 1'b0);

    do_load(16'h1234);
    push_exp(1'b0);
    check_out("load_1234");
    run_cmd("add_full", K_ADD, 4'hD, 1'b0);
    run_cmd("clr", K_CLR, 4'h0, 1'b0);

    // add fires on the same edge that load is high: load wins, no lockout.
    @(negedge sys_clk);
    hex = 4'h3; add = 1'b1;
    @(negedge sys_clk);
    add = 1'b0; load = 1'b1; data_i = 16'hBEEF;
    @(negedge sys_clk);
    load = 1'b0;
    md = 16'hBEEF; mc = 3'd4;
    push_exp(1'b0);
    push_exp(1'b0);
    check_out("load_vs_add");
    @(negedge sys_clk);
    check_out("load_vs_add_after");

    run_cmd("clr2", K_CLR, 4'h0, 1'b0);
    run_cmd("add_and_del", K_ADD | K_DEL, 4'h5, 1'b0);

    // Reset one cycle into a lockout, then a fresh add.
    model_cmd(K_ADD, 4'h9);
    push_exp(1'b1);
    pulse(K_ADD, 4'h9);
    check_out("pre_rst_add");
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    md = 16'h0000; mc = 3'd0; mo = 1'b0;
    push_exp(1'b0);
    check_out("mid_rst");
    @(negedge sys_clk);
    run_cmd("add_after_rst", K_ADD, 4'h7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
